// File: rtl/nitc_pkg.sv
// nitc_pkg: shared NITCRISC24 state encoding, default widths and opcode constants
package nitc_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, DONE = 2'b10} state_t;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam logic [3:0] OP_LW  = 4'b1010;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1011;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: memory bus (master drives req/we/addr/wdata, slave returns ack/rdata)
interface mem_access_unit_if #(parameter int DATA_W = 16, parameter int ADDR_W = 16);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;
  modport master(output bus_req, bus_we, bus_addr, bus_wdata, input bus_ack, bus_rdata);
  modport slave(input bus_req, bus_we, bus_addr, bus_wdata, output bus_ack, bus_rdata);
endinterface

// File: rtl/bus_timer.sv
// bus_timer: saturating REQ-cycle counter (clk, reset, clear, enable in; expired out on the TIMEOUT-th enabled cycle)
module bus_timer #(parameter int TIMEOUT = 255) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIM = W'(TIMEOUT - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (enable && cnt != LIM) cnt <= cnt + W'(1);
  end
  assign expired = enable && cnt == LIM;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: strobe-to-req/ack bridge holding IR/MDR (clk, reset, FSM strobes, pc/alu_out/wdata in; stall, ir, mdr, bus_err out; bus master port)
module mem_access_unit import nitc_pkg::*; #(
  parameter int DATA_W  = nitc_pkg::DATA_W,
  parameter int ADDR_W  = nitc_pkg::ADDR_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              ior_d,
  input  logic              ir_write,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic              bus_err,
  mem_access_unit_if.master bus
);
  state_t state, next;
  logic req, both, expired, we_q, irw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  assign req  = mem_read | mem_write;
  assign both = mem_read & mem_write;
  bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .reset(reset),
    .clear(state != REQ),
    .enable(state == REQ),
    .expired(expired)
  );
  always_ff @(posedge clk) state <= reset ? IDLE : next;
  always_comb begin
    next = state == IDLE ? (both ? DONE : req ? REQ : IDLE) :
           state == REQ  ? ((bus.bus_ack || expired) ? DONE : REQ) : IDLE;
  end
  always_comb begin
    stall         = (state == IDLE && req) || state == REQ;
    bus.bus_req   = state == REQ;
    bus.bus_we    = state == REQ && we_q;
    bus.bus_addr  = addr_q;
    bus.bus_wdata = wdata_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      irw_q   <= 1'b0;
      ir      <= '0;
      mdr     <= '0;
      bus_err <= 1'b0;
    end else begin
      if (state == IDLE && req && !both) begin
        addr_q  <= ior_d ? alu_out : pc;
        wdata_q <= wdata;
        we_q    <= mem_write;
        irw_q   <= ir_write;
      end
      if (state == REQ && bus.bus_ack && !we_q) begin
        if (irw_q) ir <= bus.bus_rdata;
        else mdr <= bus.bus_rdata;
      end
      // ack in the expiry cycle wins over the timeout
      if ((state == IDLE && both) || (state == REQ && !bus.bus_ack && expired)) bus_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: vector table plus scoreboard check of mem_access_unit with TIMEOUT=8
module tb_mem_access_unit;
  typedef struct {
    logic rd, wr, iord, irw;
    logic [15:0] pc, alu, wd;
    int ack_at;
    logic [15:0] rdata;
    int exp_stall;
    logic [15:0] exp_addr;
    logic exp_we;
    logic [15:0] exp_ir, exp_mdr;
    logic exp_err;
  } vec_t;
  typedef struct {logic [15:0] ir, mdr;} exp_t;
  logic clk = 0, reset = 1, mem_read = 0, mem_write = 0, ior_d = 0, ir_write = 0;
  logic [15:0] pc = 0, alu_out = 0, wdata = 0;
  logic stall, bus_err;
  logic [15:0] ir, mdr;
  int n_cmp = 0, n_bad = 0;
  vec_t vecs[8];
  exp_t sb[$];
  mem_access_unit_if #(.DATA_W(16), .ADDR_W(16)) bus();
  mem_access_unit #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(8)) dut (
    .clk(clk),
    .reset(reset),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .ior_d(ior_d),
    .ir_write(ir_write),
    .pc(pc),
    .alu_out(alu_out),
    .wdata(wdata),
    .stall(stall),
    .ir(ir),
    .mdr(mdr),
    .bus_err(bus_err),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    logic seen;
    exp_t e;
    sb.push_back('{v.exp_ir, v.exp_mdr});
    @(negedge clk);
    mem_read = v.rd; mem_write = v.wr; ior_d = v.iord; ir_write = v.irw;
    pc = v.pc; alu_out = v.alu; wdata = v.wd;
    bus.bus_ack = 0; bus.bus_rdata = v.rdata;
    #1;
    chk($sformatf("v%0d req_c0", idx), 32'(bus.bus_req), 0);
    cyc = 0;
    seen = 0;
    while (stall && cyc < 40) begin
      if (bus.bus_req) begin
        seen = 1;
        chk($sformatf("v%0d addr c%0d", idx, cyc), 32'(bus.bus_addr), 32'(v.exp_addr));
        chk($sformatf("v%0d we c%0d", idx, cyc), 32'(bus.bus_we), 32'(v.exp_we));
        chk($sformatf("v%0d wdata c%0d", idx, cyc), 32'(bus.bus_wdata), 32'(v.wd));
      end
      @(negedge clk);
      cyc++;
      bus.bus_ack = (cyc == v.ack_at);
      #1;
    end
    if (stall) begin
      n_cmp++;
      n_bad++;
      $display("FAIL v%0d hang: stall still high after %0d cycles", idx, cyc);
    end
    chk($sformatf("v%0d stall_cycles", idx), 32'(cyc), 32'(v.exp_stall));
    chk($sformatf("v%0d req_seen", idx), 32'(seen), 32'(!(v.rd && v.wr)));
    chk($sformatf("v%0d req_done", idx), 32'(bus.bus_req), 0);
    chk($sformatf("v%0d err", idx), 32'(bus_err), 32'(v.exp_err));
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL v%0d scoreboard empty", idx);
    end else begin
      e = sb.pop_front();
      chk($sformatf("v%0d ir", idx), 32'(ir), 32'(e.ir));
      chk($sformatf("v%0d mdr", idx), 32'(mdr), 32'(e.mdr));
    end
  endtask
  initial begin
    vecs[0] = '{1, 0, 0, 1, 16'h0004, 16'h0000, 16'h0000, 1, 16'hA123, 2, 16'h0004, 0, 16'hA123, 16'h0000, 0};
    vecs[1] = '{1, 0, 1, 0, 16'h0004, 16'h00F0, 16'h0000, 6, 16'h5A5A, 7, 16'h00F0, 0, 16'hA123, 16'h5A5A, 0};
    vecs[2] = '{0, 1, 1, 0, 16'h0004, 16'h0010, 16'hBEEF, 3, 16'hDEAD, 4, 16'h0010, 1, 16'hA123, 16'h5A5A, 0};
    vecs[3] = '{1, 0, 0, 1, 16'h0006, 16'h0010, 16'h0000, 2, 16'h1234, 3, 16'h0006, 0, 16'h1234, 16'h5A5A, 0};
    vecs[4] = '{1, 0, 1, 0, 16'h0006, 16'h0020, 16'h0000, 0, 16'h9999, 9, 16'h0020, 0, 16'h1234, 16'h5A5A, 1};
    vecs[5] = '{1, 0, 0, 1, 16'h0008, 16'h0020, 16'h0000, 1, 16'h7777, 2, 16'h0008, 0, 16'h7777, 16'h5A5A, 1};
    vecs[6] = '{1, 1, 1, 0, 16'h0008, 16'h0030, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h7777, 16'h5A5A, 1};
    vecs[7] = '{1, 0, 0, 1, 16'h0044, 16'h0000, 16'h0000, 1, 16'h4321, 2, 16'h0044, 0, 16'h4321, 16'h0000, 0};
    bus.bus_ack = 0;
    bus.bus_rdata = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    #1;
    chk("rst stall", 32'(stall), 0);
    chk("rst bus_req", 32'(bus.bus_req), 0);
    chk("rst bus_we", 32'(bus.bus_we), 0);
    chk("rst bus_addr", 32'(bus.bus_addr), 0);
    chk("rst bus_wdata", 32'(bus.bus_wdata), 0);
    chk("rst ir", 32'(ir), 0);
    chk("rst mdr", 32'(mdr), 0);
    chk("rst err", 32'(bus_err), 0);
    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);
    @(negedge clk);
    mem_read = 1; mem_write = 0; ior_d = 0; ir_write = 1; pc = 16'h0030;
    @(negedge clk);
    #1;
    chk("rq bus_req", 32'(bus.bus_req), 1);
    @(negedge clk);
    reset = 1;
    mem_read = 0; ir_write = 0;
    @(negedge clk);
    reset = 0;
    bus.bus_ack = 1;
    bus.bus_rdata = 16'hFFFF;
    #1;
    chk("rq idle stall", 32'(stall), 0);
    chk("rq idle bus_req", 32'(bus.bus_req), 0);
    chk("rq ir", 32'(ir), 0);
    chk("rq mdr", 32'(mdr), 0);
    chk("rq err cleared", 32'(bus_err), 0);
    @(negedge clk);
    bus.bus_ack = 0;
    #1;
    chk("rq stray ir", 32'(ir), 0);
    chk("rq stray mdr", 32'(mdr), 0);
    chk("rq stray bus_req", 32'(bus.bus_req), 0);
    run_vec(7, vecs[7]);
    @(negedge clk);
    mem_read = 0; mem_write = 0;
    #1;
    chk("end stall", 32'(stall), 0);
    chk("end sb empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
